t_flip_flop: RTL and testbench



---
 rtl/t_flip_flop_pkg.sv | 12 +
 rtl/t_ff_cell.sv | 32 +++
 rtl/t_flip_flop.sv | 60 ++++++
 tb/tb_t_flip_flop.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/t_flip_flop_pkg.sv
// Shared constants and next-state helper for the t_flip_flop bank.
// Optional feature macro: T_FLIP_FLOP_TOGGLE_COUNT_EN (see t_flip_flop.sv).
package t_flip_flop_pkg;

  localparam int   TOGGLE_CNT_W      = 16;
  localparam logic DEFAULT_RESET_BIT = 1'b0;

  function automatic logic toggle_next(input logic cur, input logic tog);
    return cur ^ tog;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit toggle register with asynchronous active-low reset to RESET_VAL.
module t_ff_cell
  import t_flip_flop_pkg::*;
#(
  parameter logic RESET_VAL = DEFAULT_RESET_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_d;
  logic q_q;

  // next state: invert when t is set, otherwise hold
  always_comb begin
    q_d = toggle_next(q_q, t);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_flip_flop.sv
// WIDTH-bit bank of independent T flip-flops with complementary outputs.
// Defining T_FLIP_FLOP_TOGGLE_COUNT_EN adds toggle_cnt, counting bit-0 toggles.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
  ,
  output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  // q_bar follows q combinationally, so it tracks reset without a clock
  assign q_bar = ~q;

`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
  logic [TOGGLE_CNT_W-1:0] cnt_d;
  logic [TOGGLE_CNT_W-1:0] cnt_q;

  // count edges at which bit 0 toggles; wraps naturally at full scale
  always_comb begin
    cnt_d = cnt_q;
    if (t[0]) begin
      cnt_d = cnt_q + TOGGLE_CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // toggle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed scoreboard bench for t_flip_flop: a 1-bit and a 4-bit instance share clk/rst_n.
module tb_t_flip_flop;

  logic        clk;
  logic        rst_n;
  logic        t1;
  logic        q1;
  logic        q_bar1;
  logic [3:0]  t4;
  logic [3:0]  q4;
  logic [3:0]  q_bar4;
`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt4;
`endif

  typedef struct {
    string       tag;
    logic        q1;
    logic [3:0]  q4;
    logic [15:0] cnt1;
    logic [15:0] cnt4;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        model;
  int          checks;
  int          errors;

  t_flip_flop u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .t          (t1),
    .q          (q1),
    .q_bar      (q_bar1)
`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
    ,
    .toggle_cnt (cnt1)
`endif
  );

  t_flip_flop #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .t          (t4),
    .q          (q4),
    .q_bar      (q_bar4)
`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
    ,
    .toggle_cnt (cnt4)
`endif
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    checks++;
    assert (sb_q.size() > 0)
    else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected %0d", sb_q.size(), 1);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_q1"},     {31'd0, q1},     {31'd0, e.q1});
      chk({e.tag, "_qbar1"},  {31'd0, q_bar1}, {31'd0, ~e.q1});
      chk({e.tag, "_q4"},     {28'd0, q4},     {28'd0, e.q4});
      chk({e.tag, "_qbar4"},  {28'd0, q_bar4}, {28'd0, ~e.q4});
`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
      chk({e.tag, "_cnt1"},   {16'd0, cnt1},   {16'd0, e.cnt1});
      chk({e.tag, "_cnt4"},   {16'd0, cnt4},   {16'd0, e.cnt4});
`endif
    end
  endtask

  // expectation for the current (no edge) state, compared right away
  task automatic check_now(input string tag);
    if (!rst_n) begin
      model.q1   = 1'b0;
      model.q4   = 4'b0000;
      model.cnt1 = 16'd0;
      model.cnt4 = 16'd0;
    end
    model.tag = tag;
    sb_q.push_back(model);
    compare_front();
  endtask

  // drive t just after an edge, predict the next edge, check 1 unit after it
  task automatic step(input string tag, input logic tv1, input logic [3:0] tv4);
    t1 = tv1;
    t4 = tv4;
    if (rst_n) begin
      model.q1   = model.q1 ^ tv1;
      model.q4   = model.q4 ^ tv4;
      model.cnt1 = model.cnt1 + {15'd0, tv1};
      model.cnt4 = model.cnt4 + {15'd0, tv4[0]};
    end else begin
      model.q1   = 1'b0;
      model.q4   = 4'b0000;
      model.cnt1 = 16'd0;
      model.cnt4 = 16'd0;
    end
    model.tag = tag;
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model.q1   = 1'b0;
    model.q4   = 4'b0000;
    model.cnt1 = 16'd0;
    model.cnt4 = 16'd0;
    model.tag  = "init";
    rst_n      = 1'b0;
    t1         = 1'b1;
    t4         = 4'b1111;

    // reset with clock running and t active
    #1;
    check_now("reset_t1");
    #2;
    rst_n = 1'b1;
    t1    = 1'b0;
    t4    = 4'b0000;
    check_now("reset_release");

    // hold, then toggle 1,1,1,0
    step("hold",    1'b0, 4'b0000);
    step("tog1",    1'b1, 4'b0000);
    step("tog2",    1'b1, 4'b0000);
    step("tog3",    1'b1, 4'b0000);
    step("tog_end", 1'b0, 4'b0000);
    chk("q1_after_toggles", {31'd0, q1}, 32'd1);

    // async reset between edges with a toggle pending
    t1 = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_now("async_rst");
    step("rst_hold1", 1'b1, 4'b1111);
    step("rst_hold2", 1'b1, 4'b1111);
    rst_n = 1'b1;

    // wide bank
    step("wide_a", 1'b0, 4'b1010);
    step("wide_b", 1'b0, 4'b0110);
    chk("q4_final",    {28'd0, q4},     {28'd0, 4'b1100});
    chk("qbar4_final", {28'd0, q_bar4}, {28'd0, 4'b0011});

    // 5 toggles then 2 holds on bit 0
    for (int i = 0; i < 5; i++) step("cnt_tog", 1'b1, 4'b0001);
    step("cnt_hold1", 1'b0, 4'b0000);
    step("cnt_hold2", 1'b0, 4'b0000);
`ifdef T_FLIP_FLOP_TOGGLE_COUNT_EN
    chk("cnt1_five", {16'd0, cnt1}, 32'd5);
`endif

    // final reset clears everything
    #1;
    rst_n = 1'b0;
    #1;
    check_now("final_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
